// File: rtl/mux_tree_ccff_bank_pkg.sv
// rtl/mux_tree_ccff_bank_pkg.sv - shared constants and width helper for the routing mux bank
// Contents:
//   MUX_SEL_LOWER  sel-bit polarity: a 1 at tree level k picks the lower-indexed branch
//   clog2()        ceiling log2, used to size sel fields, the chain and the shift counter
package mux_tree_ccff_bank_pkg;

    localparam logic MUX_SEL_LOWER = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_tree_ccff_bank_if.sv
// rtl/mux_tree_ccff_bank_if.sv - serial configuration chain interface for the routing mux bank
// Signals:
//   ccff_head     serial config data into the chain
//   cfg_shift_en  shift the chain by one bit this cycle
//   cfg_commit    one-cycle pulse copying the chain into the shadow register
//   ccff_tail     last chain bit, for cascading into the next bank
//   cfg_full      at least a full chain length shifted since reset or last commit
//   cfg_valid     shadow holds a committed configuration
// Modports: master drives the programming side, slave is the mux bank.
interface mux_tree_ccff_bank_if;

    logic ccff_head;
    logic cfg_shift_en;
    logic cfg_commit;
    logic ccff_tail;
    logic cfg_full;
    logic cfg_valid;

    modport master (
        output ccff_head,
        output cfg_shift_en,
        output cfg_commit,
        input  ccff_tail,
        input  cfg_full,
        input  cfg_valid
    );

    modport slave (
        input  ccff_head,
        input  cfg_shift_en,
        input  cfg_commit,
        output ccff_tail,
        output cfg_full,
        output cfg_valid
    );

endinterface

// File: rtl/mux_tree_param_core.sv
// rtl/mux_tree_param_core.sv - combinational N:1 mux built as a tree of 2:1 stages
// Ports:
//   en   in   1           0 forces out to 0
//   sel  in   SEL_W       level-k bit chooses between branches at tree level k
//   in   in   NUM_INPUTS  data inputs
//   out  out  1           selected input, or 0 when ~sel addresses a missing leaf
module mux_tree_param_core
    import mux_tree_ccff_bank_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int SEL_W      = clog2(NUM_INPUTS)
) (
    input  logic                  en,
    input  logic [SEL_W-1:0]      sel,
    input  logic [NUM_INPUTS-1:0] in,
    output logic                  out
);

    localparam int LEAVES = 1 << SEL_W;

    // lvl[0] holds the leaves padded to a power of two with zeros, so an
    // out-of-range selection naturally resolves to 0 at the root.
    logic [SEL_W:0][LEAVES-1:0] lvl;

    always_comb begin
        lvl = '0;
        lvl[0][NUM_INPUTS-1:0] = in;
        for (int k = 0; k < SEL_W; k++) begin
            for (int j = 0; j < (LEAVES >> (k + 1)); j++) begin
                lvl[k+1][j] = (sel[k] == MUX_SEL_LOWER) ? lvl[k][2*j] : lvl[k][2*j+1];
            end
        end
    end

    assign out = en & lvl[SEL_W][0];

endmodule

// File: rtl/mux_tree_ccff_bank.sv
// rtl/mux_tree_ccff_bank.sv - bank of N:1 routing muxes programmed through a shadowed serial chain
// Ports:
//   prog_clk  in   1                        single clock for chain, shadow, counter and out flops
//   pReset    in   1                        asynchronous active-high reset
//   cfg       slave of mux_tree_ccff_bank_if  serial chain, shift/commit controls, status
//   in        in   NUM_CHANNELS*NUM_INPUTS  channel c at in[c*NUM_INPUTS +: NUM_INPUTS]
//   out       out  NUM_CHANNELS             out[c] = selected input of channel c
module mux_tree_ccff_bank
    import mux_tree_ccff_bank_pkg::*;
#(
    parameter int NUM_INPUTS   = 4,
    parameter int NUM_CHANNELS = 2,
    parameter int REG_OUT      = 0
) (
    input  logic                               prog_clk,
    input  logic                               pReset,
    mux_tree_ccff_bank_if.slave                cfg,
    input  logic [NUM_CHANNELS*NUM_INPUTS-1:0] in,
    output logic [NUM_CHANNELS-1:0]            out
);

    localparam int SEL_W     = clog2(NUM_INPUTS);
    localparam int CHAIN_LEN = NUM_CHANNELS * SEL_W;
    localparam int CNT_W     = clog2(CHAIN_LEN + 1);

    logic [CHAIN_LEN-1:0]    chain;
    logic [CHAIN_LEN-1:0]    chain_next;
    logic [CHAIN_LEN-1:0]    shadow;
    logic [CNT_W-1:0]        count;
    logic                    valid;
    logic [NUM_CHANNELS-1:0] mux_out;

    // Written as shift-then-patch so a one-bit chain needs no special case.
    always_comb begin
        chain_next = chain << 1;
        chain_next[0] = cfg.ccff_head;
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            chain  <= '0;
            shadow <= '0;
            count  <= '0;
            valid  <= 1'b0;
        end else begin
            if (cfg.cfg_shift_en) begin
                chain <= chain_next;
            end
            // Commit samples the pre-edge chain; a coincident shift is counted
            // as the first bit of the next configuration.
            if (cfg.cfg_commit) begin
                shadow <= chain;
                valid  <= 1'b1;
                count  <= cfg.cfg_shift_en ? CNT_W'(1) : '0;
            end else if (cfg.cfg_shift_en && (count != CNT_W'(CHAIN_LEN))) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign cfg.ccff_tail = chain[CHAIN_LEN-1];
    assign cfg.cfg_full  = (count == CNT_W'(CHAIN_LEN));
    assign cfg.cfg_valid = valid;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        mux_tree_param_core #(
            .NUM_INPUTS (NUM_INPUTS),
            .SEL_W      (SEL_W)
        ) u_core (
            .en  (valid),
            .sel (shadow[c*SEL_W +: SEL_W]),
            .in  (in[c*NUM_INPUTS +: NUM_INPUTS]),
            .out (mux_out[c])
        );
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic [NUM_CHANNELS-1:0] out_q;
        always_ff @(posedge prog_clk or posedge pReset) begin
            if (pReset) begin
                out_q <= '0;
            end else begin
                out_q <= mux_out;
            end
        end
        assign out = out_q;
    end else begin : g_comb_out
        assign out = mux_out;
    end

endmodule
